// File: rtl/shapool_pkg.sv
// Shared constants for the SHA pool nonce sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shapool_pkg;

    localparam int ROUNDS_DEFAULT = 64;  // cycles per hash stage
    localparam int NONCE_W        = 32;  // nonce / digest word width
    localparam int DIFF_W         = 8;   // difficulty field width
    localparam int DIFF_SAT       = 32;  // difficulty beyond one word saturates here

endpackage

// File: rtl/shapool_sequencer_difficulty_check.sv
// Leading-zero test of one digest word against the required difficulty.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module difficulty_check
    import shapool_pkg::*;
(
    input  logic [NONCE_W-1:0] word,
    input  logic [DIFF_W-1:0]  difficulty,
    output logic               match
);

    logic [5:0]         need;
    logic [NONCE_W-1:0] mask;

    // Saturate the difficulty to one word, build a mask of the top 'need' bits, require them all zero.
    // A shift by the full word width yields zero, so need==32 gives an all-ones mask and need==0 an empty one.
    always_comb begin
        need  = (difficulty > DIFF_W'(DIFF_SAT)) ? 6'(DIFF_SAT) : difficulty[5:0];
        mask  = ~({NONCE_W{1'b1}} >> need);
        match = ((word & mask) == '0);
    end

endmodule

// File: rtl/shapool_sequencer.sv
// Drives round/nonce to a pool of hash cores and latches the first nonce whose digest meets difficulty.
// Latency: success/flags/result registered one cycle after the digest_valid pulse.
// Backpressure: none; a found match (or exhaustion when SHAPOOL_EXHAUST_EN is defined) freezes the search until core_reset_n low.
module shapool_sequencer
    import shapool_pkg::*;
#(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int ROUNDS         = ROUNDS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    core_reset_n,
    input  logic [7:0]              device_config,
    input  logic [DIFF_W-1:0]       difficulty,
    input  logic                    digest_valid,
    input  logic [POOL_SIZE*32-1:0] digest_msw,
    output logic [5:0]              round,
    output logic                    stage_start,
    output logic [NONCE_W-1:0]      nonce,
    output logic [POOL_SIZE-1:0]    shapool_match_flags,
    output logic [NONCE_W-1:0]      shapool_result,
`ifdef SHAPOOL_EXHAUST_EN
    output logic                    exhausted,
`endif
    output logic                    shapool_success
);

    // Top POOL_SIZE_LOG2 nonce bits belong to the core index, so they stay zero here.
    localparam logic [NONCE_W-1:0] NONCE_MASK = {NONCE_W{1'b1}} >> POOL_SIZE_LOG2;

    logic                 armed;
    logic                 hold;
    logic                 running;
    logic                 round_last;
    logic [5:0]           round_nxt;
    logic [NONCE_W-1:0]   nonce_load;
    logic [NONCE_W-1:0]   nonce_inc;
    logic [POOL_SIZE-1:0] match;

`ifdef SHAPOOL_EXHAUST_EN
    logic [NONCE_W-1:0]   nonce_base;
`endif

    for (genvar i = 0; i < POOL_SIZE; i++) begin : g_check
        difficulty_check u_check (
            .word       (digest_msw[32*i +: 32]),
            .difficulty (difficulty),
            .match      (match[i])
        );
    end

    // The very first edge after reset_n release is treated as a hold, whatever core_reset_n says.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) armed <= 1'b0;
        else          armed <= 1'b1;
    end

    // Next-state helpers for round and nonce.
    always_comb begin
        hold       = !core_reset_n || !armed;
`ifdef SHAPOOL_EXHAUST_EN
        running    = !shapool_success && !exhausted;
`else
        running    = !shapool_success;
`endif
        round_last = (round == 6'(ROUNDS - 1));
        round_nxt  = round_last ? 6'd0 : round + 6'd1;
        nonce_load = {device_config, {(NONCE_W-8){1'b0}}} >> POOL_SIZE_LOG2;
        nonce_inc  = (nonce + 1'b1) & NONCE_MASK;
    end

    // Search sequencer: hold/load, advance round and nonce, capture the first match, then freeze.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round               <= '0;
            stage_start         <= 1'b0;
            nonce               <= '0;
            shapool_success     <= 1'b0;
            shapool_match_flags <= '0;
            shapool_result      <= '0;
`ifdef SHAPOOL_EXHAUST_EN
            exhausted           <= 1'b0;
            nonce_base          <= '0;
`endif
        end else if (hold) begin
            round               <= '0;
            stage_start         <= 1'b0;
            nonce               <= nonce_load;
            shapool_success     <= 1'b0;
            shapool_match_flags <= '0;
            shapool_result      <= '0;
`ifdef SHAPOOL_EXHAUST_EN
            exhausted           <= 1'b0;
            nonce_base          <= nonce_load;
`endif
        end else if (running) begin
            round       <= round_nxt;
            stage_start <= (round_nxt == 6'd0);
            if (round_last) begin
                nonce <= nonce_inc;
`ifdef SHAPOOL_EXHAUST_EN
                if (nonce_inc == nonce_base) exhausted <= 1'b1;
`endif
            end
            // Result is the nonce in the pulse cycle, before any coincident increment.
            if (digest_valid && (|match)) begin
                shapool_success     <= 1'b1;
                shapool_match_flags <= match;
                shapool_result      <= nonce;
            end
        end else begin
            // Frozen: state holds; stage_start still tracks round==0 with core_reset_n high.
            stage_start <= (round == 6'd0);
        end
    end

endmodule

// File: doc/shapool_sequencer.md
SHAPOOL_SEQUENCER -- requirements
Module: shapool_sequencer

Interface
REQ-001 SHALL have parameter POOL_SIZE, default 2, number of hash cores.
REQ-002 SHALL have parameter POOL_SIZE_LOG2, default 1, ceil(log2(POOL_SIZE)).
REQ-003 SHALL have parameter ROUNDS, default 64, cycles per hash stage.
REQ-004 SHALL have port clk  in  1  sole clock.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port core_reset_n  in  1  synchronous halt/clear from the IO block; low = hold.
REQ-007 SHALL have port device_config  in  8  nonce_start byte.
REQ-008 SHALL have port difficulty  in  8  required leading-zero bit count (job_config[7:0]).
REQ-009 SHALL have port digest_valid  in  1  one-cycle pulse: second-stage digests are valid.
REQ-010 SHALL have port digest_msw  in  POOL_SIZE*32  top digest word per core, core i at [32i+31:32i].
REQ-011 SHALL have port round  out  6  current round index to the cores.
REQ-012 SHALL have port stage_start  out  1  pulse when round==0 (new nonce enters the pipe).
REQ-013 SHALL have port nonce  out  32  current base nonce; top POOL_SIZE_LOG2 bits always 0.
REQ-014 SHALL have port shapool_match_flags  out  POOL_SIZE  per-core match, captured at success.
REQ-015 SHALL have port shapool_result  out  32  nonce captured at success.
REQ-016 SHALL have port shapool_success  out  1  sticky success flag.

Function
REQ-017 While core_reset_n low: round=0, stage_start=0, success/flags/result cleared, nonce loaded with ({device_config,24'h0} >> POOL_SIZE_LOG2).
REQ-018 While core_reset_n high and shapool_success low: round increments each cycle, 0..ROUNDS-1, wraps to 0.
REQ-019 stage_start SHALL be 1 exactly in cycles where round==0 and core_reset_n was high the previous cycle.
REQ-020 On round wrap (ROUNDS-1 -> 0) nonce SHALL increment by 1 in its low (32-POOL_SIZE_LOG2) bits, modulo that width; top bits stay 0.
REQ-021 Match for core i: top min(difficulty,32) bits of its digest_msw are all zero; difficulty 0 = always match; difficulty >32 saturates to 32.
REQ-022 On digest_valid with any match: next cycle shapool_success=1, flags=match vector, result=nonce value in the digest_valid cycle (pre-increment if wrap coincides).
REQ-023 After success: round, nonce, success, flags, result frozen until core_reset_n low; further digest_valid ignored.
REQ-024 digest_valid while core_reset_n low SHALL be ignored; core_reset_n low in the same cycle as a match SHALL win (no success).

Reset
REQ-025 reset_n low SHALL asynchronously force round=0, nonce=0, stage_start=0, success=0, flags=0, result=0.
REQ-026 First cycle after reset_n release SHALL behave as core_reset_n low regardless of core_reset_n.

Configuration
REQ-027 Macro SHAPOOL_EXHAUST_EN defined: on nonce wrap back to its load value, sequencer halts as in REQ-023 with success=0, and an extra output exhausted (1 bit) goes high until core_reset_n low.
REQ-028 Macro SHAPOOL_EXHAUST_EN undefined: no exhausted port; nonce wraps modulo and search continues indefinitely.

Structure
REQ-029 ROUNDS default, nonce width (32), difficulty width (8) and the saturation limit (32) SHALL live in shared package shapool_pkg.
REQ-030 Per-core leading-zero comparison SHALL be sub-module difficulty_check (one 32-bit word + difficulty in, match out), instantiated POOL_SIZE times.

Verification
REQ-031 device_config=0x80, POOL_SIZE=2, release core_reset_n -> nonce=0x40000000, stage_start at round 0, nonce=0x40000001 after 64 cycles.
REQ-032 difficulty=8, digest_msw core1=0x00FFFFFF, core0=0x01000000, digest_valid -> next cycle success=1, flags=2'b10, result=nonce at pulse.
REQ-033 difficulty=0, digest_valid coinciding with round=63 -> result equals pre-increment nonce, round frozen at 0.
REQ-034 difficulty=40, digest_msw all 0x00000000 -> match (saturation); digest_msw 0x00000001 -> no match.
REQ-035 reset_n asserted mid-search with success=1 -> all outputs 0 immediately, no clk edge needed.
REQ-036 SHAPOOL_EXHAUST_EN, POOL_SIZE_LOG2=1, ROUNDS forced 1, nonce start 0x7FFFFFFF -> wraps to 0, exhausted=1 when nonce returns to start.
